keypad_onehot_decoder: RTL and testbench



---
 rtl/keypad_onehot_decoder_pkg.sv | 38 +++
 rtl/keypad_onehot_decoder_sync.sv | 26 ++
 rtl/keypad_onehot_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_onehot_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_onehot_decoder_pkg.sv
// Shared key map, FSM encodings and bit-count helpers for the keypad decoder.
// Map covers 16 key lines; wider key vectors treat the extra lines as unmapped.
package keypad_pkg;

    localparam int MAP_KEYS   = 16;
    localparam int MAP_CODE_W = 4;
    localparam int MAX_KEYS   = 64;

    // Element [i] is the code for key line i; concatenation lists line 15 first.
    localparam logic [MAP_KEYS-1:0][MAP_CODE_W-1:0] KEY_MAP = {
        4'd7, 4'd8, 4'd9, 4'd0,
        4'd4, 4'd5, 4'd6, 4'd0,
        4'd1, 4'd2, 4'd3, 4'd0,
        4'd0, 4'd0, 4'd0, 4'd0
    };
    localparam logic [MAP_KEYS-1:0] KEY_MAP_VLD = 16'hEEE8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [6:0] popcount(input logic [MAX_KEYS-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    function automatic logic is_onehot(input logic [MAX_KEYS-1:0] v);
        return popcount(v) == 7'd1;
    endfunction

endpackage

// File: rtl/keypad_onehot_decoder_sync.sv
// N-bit two-flop synchroniser for asynchronous key lines; 2-cycle latency, no backpressure.
module onehot_sync_2ff #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/keypad_onehot_decoder.sv
// Keypad front end: 2-flop sync, debounce FSM, one-hot to code map; no backpressure.
// key_valid follows 2+DEBOUNCE_CYC stable edges; KEY_REPEAT_EN adds hold auto-repeat.
module keypad_onehot_decoder
    import keypad_pkg::*;
#(
    parameter int N_KEYS       = 16,
    parameter int CODE_W       = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 16,
    parameter int REPEAT_DLY   = 1000,
    parameter int REPEAT_PER   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] onehot_in,
    output logic [CODE_W-1:0] code_out,
    output logic              key_valid,
    output logic              key_held,
    output logic              err_multi,
    output logic [CNT_W-1:0]  press_count
);

    localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    function automatic logic map_vld(input logic [IDX_W-1:0] idx);
        logic v;
        v = 1'b0;
        for (int i = 0; i < MAP_KEYS; i++) begin
            if (int'(idx) == i) v = KEY_MAP_VLD[i];
        end
        return v;
    endfunction

    function automatic logic [CODE_W-1:0] map_code(input logic [IDX_W-1:0] idx);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAP_KEYS; i++) begin
            if (int'(idx) == i) c = CODE_W'(KEY_MAP[i]);
        end
        return c;
    endfunction

    logic [N_KEYS-1:0] syn;
    logic [IDX_W-1:0]  syn_idx;
    logic [6:0]        syn_ones;
    logic              syn_single;
    logic              syn_mapped;
    logic              syn_is_cand;

    state_t            state_q, state_d;
    logic [DB_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;
    logic              rep_fire;

    onehot_sync_2ff #(.W(N_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (onehot_in),
        .q_out (syn)
    );

    always_comb begin
        syn_idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (syn[i]) syn_idx = IDX_W'(i);
        end
    end

    assign syn_ones    = popcount(MAX_KEYS'(syn));
    assign syn_single  = is_onehot(MAX_KEYS'(syn));
    assign syn_mapped  = map_vld(syn_idx);
    assign syn_is_cand = (syn == (N_KEYS'(1) << cand_q));
    assign cnt_inc     = cnt_q + DB_W'(1);

`ifdef KEY_REPEAT_EN
    logic [31:0] hold_q, hold_d, hold_inc;
    logic        rep_q, rep_d;

    // Counter runs only while the accepted key is still held; any exit resets it.
    always_comb begin
        hold_d   = '0;
        rep_d    = 1'b0;
        rep_fire = 1'b0;
        hold_inc = hold_q + 32'd1;
        if (state_q == PRESSED && syn_is_cand) begin
            hold_d = hold_inc;
            rep_d  = rep_q;
            if (hold_inc == (rep_q ? 32'(REPEAT_PER) : 32'(REPEAT_DLY))) begin
                rep_fire = 1'b1;
                hold_d   = '0;
                rep_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    logic [31:0] unused_repeat_cfg;
    assign unused_repeat_cfg = 32'(REPEAT_DLY) ^ 32'(REPEAT_PER);
    assign rep_fire          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        err_d   = err_q;
        count_d = count_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (syn_single && syn_mapped) begin
                    cand_d = syn_idx;
                    cnt_d  = DB_W'(1);
                    if (DEBOUNCE_CYC == 1) accept = 1'b1;
                    else                   state_d = DEBOUNCE;
                end else if (syn_ones > 7'd1) begin
                    err_d = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (syn_is_cand) begin
                    if (cnt_inc == DB_W'(DEBOUNCE_CYC)) accept = 1'b1;
                    else                                cnt_d  = cnt_inc;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!syn_is_cand) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (rep_fire) begin
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // A different key while releasing restarts the zero run, never a new press.
                if (syn == '0) begin
                    if (cnt_inc == DB_W'(DEBOUNCE_CYC)) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (syn_is_cand) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = PRESSED;
            cnt_d   = '0;
            code_d  = map_code(cand_d);
            valid_d = 1'b1;
            held_d  = 1'b1;
            err_d   = 1'b0;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign code_out    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign err_multi   = err_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_keypad_onehot_decoder.sv
// Directed bench for keypad_onehot_decoder with DEBOUNCE_CYC=4 and a 4-bit press counter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_onehot_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] onehot_in;
    logic [3:0]  code_out;
    logic        key_valid;
    logic        key_held;
    logic        err_multi;
    logic [3:0]  press_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_onehot_decoder #(
        .N_KEYS       (16),
        .CODE_W       (4),
        .DEBOUNCE_CYC (4),
        .CNT_W        (4),
        .REPEAT_DLY   (10),
        .REPEAT_PER   (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .onehot_in   (onehot_in),
        .code_out    (code_out),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .err_multi   (err_multi),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] v);
        onehot_in = v;
        step(10);
        onehot_in = '0;
        step(12);
    endtask

    initial begin
        rst_n     = 1'b1;
        onehot_in = 16'($urandom);
        #2 rst_n  = 1'b0;
        step(3);
        check("rst_code",  code_out,    0);
        check("rst_valid", key_valid,   0);
        check("rst_held",  key_held,    0);
        check("rst_err",   err_multi,   0);
        check("rst_count", press_count, 0);

        onehot_in = '0;
        rst_n     = 1'b1;
        step(5);
        check("idle_valid", key_valid,   0);
        check("idle_count", press_count, 0);
        check("idle_code",  code_out,    0);

        // Single clean press of line 5 -> code 3, pulse on the 6th edge.
        onehot_in = 16'h0020;
        step(5);
        check("s2_early_valid", key_valid, 0);
        step(1);
        check("s2_valid", key_valid,   1);
        check("s2_code",  code_out,    3);
        check("s2_count", press_count, 1);
        check("s2_held",  key_held,    1);
        step(1);
        check("s2_valid_drop", key_valid, 0);
        step(5);
        onehot_in = '0;
        step(6);
        check("s2_held_release", key_held, 1);
        step(1);
        check("s2_held_clear", key_held, 0);
        check("s2_pulses",     pulses,   1);

        // Bounce on line 11 then stable -> exactly one pulse, code 4.
        for (int r = 0; r < 3; r++) begin
            onehot_in = 16'h0800;
            step(2);
            onehot_in = '0;
            step(1);
        end
        check("s3_bounce_pulses", pulses, 1);
        onehot_in = 16'h0800;
        step(5);
        check("s3_early_valid", key_valid, 0);
        step(1);
        check("s3_valid", key_valid,   1);
        check("s3_code",  code_out,    4);
        check("s3_count", press_count, 2);
        onehot_in = '0;
        step(12);
        check("s3_held_clear", key_held, 0);
        check("s3_pulses",     pulses,   2);

        // Unmapped line 0 held -> nothing happens, code stays 4.
        onehot_in = 16'h0001;
        step(20);
        check("s5_unmapped_pulses", pulses,      2);
        check("s5_unmapped_code",   code_out,    4);
        check("s5_unmapped_held",   key_held,    0);
        check("s5_unmapped_count",  press_count, 2);
        onehot_in = '0;
        step(4);

        // Multi-hot sets err_multi; a following clean press clears it.
        onehot_in = 16'h0028;
        step(10);
        check("s4_err_set",    err_multi, 1);
        check("s4_err_pulses", pulses,    2);
        check("s4_err_code",   code_out,  4);
        onehot_in = 16'h0008;
        step(5);
        check("s4_early_valid", key_valid, 0);
        check("s4_err_hold",    err_multi, 1);
        step(1);
        check("s4_valid",     key_valid,   1);
        check("s4_code",      code_out,    0);
        check("s4_err_clear", err_multi,   0);
        check("s4_count",     press_count, 3);
        onehot_in = '0;
        step(12);
        check("s4_pulses", pulses, 3);

        // Reset in the middle of debounce: state and outputs drop at once.
        onehot_in = 16'h0020;
        step(4);
        rst_n = 1'b0;
        #1;
        check("rst_db_count", press_count, 0);
        check("rst_db_valid", key_valid,   0);
        check("rst_db_held",  key_held,    0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("rst_db_no_early", key_valid, 0);
        step(1);
        check("rst_db_valid_after", key_valid,   1);
        check("rst_db_code_after",  code_out,    3);
        check("rst_db_count_after", press_count, 1);

        // Reset while pressed.
        step(3);
        rst_n = 1'b0;
        #1;
        check("rst_pr_held",  key_held,    0);
        check("rst_pr_code",  code_out,    0);
        check("rst_pr_count", press_count, 0);
        onehot_in = '0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("rst_pr_pulses", pulses, 4);

        // Fifteen presses bring the 4-bit counter to its top value, the next wraps it.
        for (int k = 0; k < 15; k++) begin
            press(16'h0020);
        end
        check("s6_count_top", press_count, 4'hF);
        onehot_in = 16'h4000;
        step(6);
        check("s6_wrap_valid", key_valid,   1);
        check("s6_wrap_code",  code_out,    8);
        check("s6_wrap_count", press_count, 0);
        onehot_in = '0;
        step(12);
        check("s6_pulses", pulses, 20);

        // Long hold of line 13 -> code 9.
        onehot_in = 16'h2000;
        step(6);
        check("hold_valid", key_valid,   1);
        check("hold_code",  code_out,    9);
        check("hold_count", press_count, 1);
`ifdef KEY_REPEAT_EN
        step(9);
        check("rep_before_first", key_valid, 0);
        step(1);
        check("rep_first", key_valid, 1);
        step(5);
        check("rep_second", key_valid, 1);
        step(5);
        check("rep_third", key_valid, 1);
        step(5);
        check("rep_fourth", key_valid, 1);
        check("rep_count",  press_count, 5);
        check("rep_code",   code_out,    9);
        onehot_in = '0;
        step(12);
        check("rep_pulses",     pulses,   25);
        check("rep_held_clear", key_held, 0);
`else
        step(24);
        onehot_in = '0;
        step(12);
        check("hold_pulses",     pulses,      21);
        check("hold_count_end",  press_count, 1);
        check("hold_held_clear", key_held,    0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
